game_frame_ctrl: RTL
====================

// Module: game_frame_ctrl
// PURPOSE
//  Game-level controller and pixel compositor for the flappy-bird datapath.
//  Owns the game state machine, BCD score and high score, and the registered RGB mux.
//  Accepts NUM_PIPES independent pipe channels and a death-flash overlay.
//  Sits between the VGA timing generator, bird_physics/bird_rom and the pipe renderers.
// PARAMETERS
//  NUM_PIPES     3       pipe channels; legal range 1..9
//  SCORE_DIGITS  4       BCD digits in score and high_score
//  FLASH_FRAMES  30      frames spent in DYING; legal range 1..255
//  BIRD_X        200     left column of the bird sprite
//  SPRITE_W/H    24/24   bird sprite size in pixels
//  KEY_COLOR     12'hF0F sprite transparent colour key
//  BG_COLOR      12'h5CC background colour
//  PIPE_COLOR    12'h0F0 pipe colour
//  FLASH_COLOR   12'hFFF death-flash overlay colour
// PORTS
//  clk         in   1              pixel clock
//  reset       in   1              asynchronous, active-low reset (0 = reset)
//  bright      in   1              visible-area flag for the current hCount/vCount
//  hCount      in   10             current pixel column
//  vCount      in   10             current pixel row
//  frame_tick  in   1              one-cycle pulse, once per frame
//  button      in   1              debounced flap/start button, asynchronous level
//  bird_y      in   10             top row of the bird
//  sprite_px   in   12             bird ROM pixel for the current hCount/vCount
//  pipe_pixel  in   NUM_PIPES      per-channel pipe-covers-pixel flag
//  pipe_pass   in   NUM_PIPES      per-channel bird-passed-pipe level
//  collision   in   1              bird hit a pipe or a boundary
//  game_run    out  1              1 only in PLAY; enables physics and pipes
//  game_start  out  1              one-cycle pulse on entry to PLAY
//  state       out  2              IDLE=0, PLAY=1, DYING=2, OVER=3
//  rgb         out  12             registered pixel colour
//  score       out  4*SCORE_DIGITS BCD score; digit 0 in bits [3:0]
//  high_score  out  4*SCORE_DIGITS BCD best score
// BEHAVIOUR
//  Reset values: state=IDLE; score=0; high_score=0; rgb=0; game_run=0;
//   game_start=0; all internal registers=0. Reset is legal in any state.
//  Button handling: button passes through a 2-flop synchroniser, then a rising-edge
//   detect. An edge registers 3 clocks after the button rises.
//  FSM transitions:
//   IDLE -> PLAY on a button edge. The same edge clears score and pulses game_start.
//   PLAY -> DYING when collision=1. flash_cnt is loaded with FLASH_FRAMES.
//    The button is ignored in PLAY.
//   DYING: flash_cnt decrements on each frame_tick.
//    DYING -> OVER on the frame_tick that makes flash_cnt 0.
//    On that same edge, high_score <= score if score > high_score.
//    Compare the concatenated BCD values as unsigned numbers.
//   OVER -> IDLE on a button edge.
//   collision and pipe_pass are ignored outside PLAY.
//  Score:
//   Each channel has its own prev_pass register. The counter adds k, where k is the
//    popcount of rising pass edges in that cycle (0..NUM_PIPES), as a BCD add.
//   Carry ripples across all digits in the same cycle.
//   Score saturates at all-9s and does not wrap.
//   A pass and a collision in the same PLAY cycle: the pass is counted, then DYING.
//   prev_pass keeps updating in every state, so a pass level still high on entry
//    to PLAY is not counted.
//  Pixel path: exactly 1 clock of latency from hCount/vCount/bright/sprite_px/pipe_pixel
//   to rgb. Priority, evaluated in this order:
//   1. !bright -> 12'h000
//   2. state==DYING && flash_cnt[1] -> FLASH_COLOR
//   3. pixel inside the bird box and sprite_px != KEY_COLOR -> sprite_px
//      Bird box: BIRD_X <= h < BIRD_X+SPRITE_W, bird_y <= v < bird_y+SPRITE_H.
//   4. state != IDLE and |pipe_pixel -> PIPE_COLOR
//   5. otherwise -> BG_COLOR
// TESTING
//  1. Reset low mid-PLAY with score=0x0042 -> next cycle: state=0, score=0,
//     high_score=0, rgb=0.
//  2. Button rises in IDLE -> state=1 and game_start=1 for one cycle, 3 clocks later;
//     score=0.
//  3. PLAY, pipe_pass=3'b101 rising in one cycle -> score 0x0008 to 0x0010 (BCD carry).
//     Score 0x9999 plus one pass -> stays 0x9999.
//  4. collision in the same cycle as a pass edge with score=0x0004 -> score=0x0005,
//     state=2. After FLASH_FRAMES frame_ticks: state=3, high_score=0x0005.
//  5. Second game ends with score 0x0003 -> high_score remains 0x0005.
//     Button rises in OVER -> IDLE.
//  6. Pixel at (205, bird_y+1) with sprite_px=KEY_COLOR and pipe_pixel=001 in PLAY
//     -> rgb=12'h0F0 one clock later. Same pixel in IDLE -> 12'h5CC.
//     bright=0 -> 12'h000.

Source files
------------

// File: rtl/game_frame_if.sv
// game_frame_if: bundles the video, control and status signals of game_frame_ctrl
//   master: drives bright, hCount, vCount, frame_tick, button, bird_y, sprite_px,
//           pipe_pixel, pipe_pass, collision; receives game_run, game_start, state,
//           rgb, score, high_score
//   slave:  the controller side, directions mirrored
interface game_frame_if #(
    parameter int NUM_PIPES    = 3,
    parameter int SCORE_DIGITS = 4
);
    logic                      bright;
    logic [9:0]                hCount;
    logic [9:0]                vCount;
    logic                      frame_tick;
    logic                      button;
    logic [9:0]                bird_y;
    logic [11:0]               sprite_px;
    logic [NUM_PIPES-1:0]      pipe_pixel;
    logic [NUM_PIPES-1:0]      pipe_pass;
    logic                      collision;
    logic                      game_run;
    logic                      game_start;
    logic [1:0]                state;
    logic [11:0]               rgb;
    logic [4*SCORE_DIGITS-1:0] score;
    logic [4*SCORE_DIGITS-1:0] high_score;
    modport master (
        output bright, hCount, vCount, frame_tick, button, bird_y, sprite_px,
               pipe_pixel, pipe_pass, collision,
        input  game_run, game_start, state, rgb, score, high_score
    );
    modport slave (
        input  bright, hCount, vCount, frame_tick, button, bird_y, sprite_px,
               pipe_pixel, pipe_pass, collision,
        output game_run, game_start, state, rgb, score, high_score
    );
endinterface

// File: rtl/game_frame_ctrl.sv
// game_frame_ctrl: game state machine, BCD score/high score and registered pixel mux
//   clk   pixel clock
//   reset asynchronous active-low reset
//   bus   game_frame_if.slave: video/sprite/pipe inputs, button, collision,
//         frame_tick in; game_run, game_start, state, rgb, score, high_score out
module game_frame_ctrl #(
    parameter int          NUM_PIPES    = 3,
    parameter int          SCORE_DIGITS = 4,
    parameter int          FLASH_FRAMES = 30,
    parameter int          BIRD_X       = 200,
    parameter int          SPRITE_W     = 24,
    parameter int          SPRITE_H     = 24,
    parameter logic [11:0] KEY_COLOR    = 12'hF0F,
    parameter logic [11:0] BG_COLOR     = 12'h5CC,
    parameter logic [11:0] PIPE_COLOR   = 12'h0F0,
    parameter logic [11:0] FLASH_COLOR  = 12'hFFF
) (
    input logic         clk,
    input logic         reset,
    game_frame_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PLAY  = 2'd1;
    localparam logic [1:0] DYING = 2'd2;
    localparam logic [1:0] OVER  = 2'd3;
    localparam int SW = 4 * SCORE_DIGITS;

    logic [1:0]           btn_sync_q;
    logic                 btn_prev_q;
    logic [NUM_PIPES-1:0] prev_pass_q;
    logic [1:0]           state_q, state_d;
    logic [SW-1:0]        score_q, score_d, high_q, high_d, score_add, score_inc;
    logic [7:0]           flash_cnt_q, flash_cnt_d;
    logic                 start_q, start_d;
    logic [11:0]          rgb_q, rgb_d;
    logic                 btn_edge, in_box;
    logic [3:0]           k, carry;
    logic [4:0]           sum;

    assign btn_edge = btn_sync_q[1] & ~btn_prev_q;
    assign k        = 4'($countones(bus.pipe_pass & ~prev_pass_q));

    // Ripple BCD add of k; any carry out of the top digit means the result passed all-9s
    always_comb begin
        carry     = k;
        sum       = '0;
        score_add = '0;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            sum = {1'b0, score_q[4*i +: 4]} + {1'b0, carry};
            score_add[4*i +: 4] = (sum >= 5'd10) ? 4'(sum - 5'd10) : sum[3:0];
            carry = (sum >= 5'd10) ? 4'd1 : 4'd0;
        end
        score_inc = (carry != 4'd0) ? {SCORE_DIGITS{4'h9}} : score_add;
    end

    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        high_d      = high_q;
        flash_cnt_d = flash_cnt_q;
        start_d     = 1'b0;
        case (state_q)
            IDLE: if (btn_edge) begin
                state_d = PLAY;
                score_d = '0;
                start_d = 1'b1;
            end
            PLAY: begin
                score_d = score_inc;
                if (bus.collision) begin
                    state_d     = DYING;
                    flash_cnt_d = 8'(FLASH_FRAMES);
                end
            end
            DYING: if (bus.frame_tick) begin
                flash_cnt_d = flash_cnt_q - 8'd1;
                if (flash_cnt_q == 8'd1) begin
                    state_d = OVER;
                    high_d  = (score_q > high_q) ? score_q : high_q;
                end
            end
            default: if (btn_edge) state_d = IDLE;
        endcase
    end

    assign in_box = ({1'b0, bus.hCount} >= 11'(BIRD_X)) &&
                    ({1'b0, bus.hCount} <  11'(BIRD_X + SPRITE_W)) &&
                    ({1'b0, bus.vCount} >= {1'b0, bus.bird_y}) &&
                    ({1'b0, bus.vCount} <  {1'b0, bus.bird_y} + 11'(SPRITE_H));

    assign rgb_d = !bus.bright                                ? 12'h000 :
                   (state_q == DYING && flash_cnt_q[1])       ? FLASH_COLOR :
                   (in_box && bus.sprite_px != KEY_COLOR)     ? bus.sprite_px :
                   (state_q != IDLE && |bus.pipe_pixel)       ? PIPE_COLOR : BG_COLOR;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_sync_q  <= '0;
            btn_prev_q  <= 1'b0;
            prev_pass_q <= '0;
            state_q     <= IDLE;
            score_q     <= '0;
            high_q      <= '0;
            flash_cnt_q <= '0;
            start_q     <= 1'b0;
            rgb_q       <= '0;
        end else begin
            btn_sync_q  <= {btn_sync_q[0], bus.button};
            btn_prev_q  <= btn_sync_q[1];
            prev_pass_q <= bus.pipe_pass;
            state_q     <= state_d;
            score_q     <= score_d;
            high_q      <= high_d;
            flash_cnt_q <= flash_cnt_d;
            start_q     <= start_d;
            rgb_q       <= rgb_d;
        end
    end

    assign bus.game_run   = (state_q == PLAY);
    assign bus.game_start = start_q;
    assign bus.state      = state_q;
    assign bus.rgb        = rgb_q;
    assign bus.score      = score_q;
    assign bus.high_score = high_q;
endmodule
